// File: rtl/exec_sequencer.sv
// Multi-cycle execution sequencer: holds the ALU for an op's latency, runs a
// data-memory request/acknowledge for LOAD/STORE, then issues one writeback.
module exec_sequencer #(
  parameter int MUL_CYCLES  = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       issue_valid,
  output logic       issue_ready,
  input  logic [5:0] opcode,
  output logic       alu_en,
  output logic [3:0] alu_op,
  output logic       mem_req,
  output logic       mem_we,
  input  logic       mem_ack,
  output logic       wb_en,
  output logic       wb_sel_mem,
  output logic       done,
  output logic       illegal,
  output logic       timeout,
  output logic       busy,
  output logic [1:0] stateDbg
);

  localparam int CNT_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int TMR_W   = $clog2(MEM_TIMEOUT + 1);

  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, EXEC, MEM, WB} stateT;
  typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_LOAD, OP_STORE, OP_BAD} opKindT;

  stateT            state, stateNext;
  opKindT           curOp, opNext, decoded;
  logic [CNT_W-1:0] cnt, cntNext;
  logic [TMR_W-1:0] tmr, tmrNext;
  logic [3:0]       aluOpNext;
  logic             illegalNext, timeoutNext, storeDone, wbFromMem;

  function automatic opKindT decodeOp(input logic [5:0] opc);
    case (opc)
      6'b011111: return OP_ADD;
      6'b011110: return OP_SUB;
      6'b011101: return OP_MUL;
      6'b011100: return OP_DIV;
      6'b100001: return OP_LOAD;
      6'b101010: return OP_STORE;
      default:   return OP_BAD;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] latencyOf(input opKindT k);
    case (k)
      OP_MUL:  return MUL_LAST;
      OP_DIV:  return DIV_LAST;
      default: return '0;
    endcase
  endfunction

  function automatic logic [3:0] aluCodeOf(input opKindT k);
    case (k)
      OP_SUB:  return 4'b0001;
      OP_MUL:  return 4'b0010;
      OP_DIV:  return 4'b0011;
      default: return 4'b0000;
    endcase
  endfunction

  // Handshake: an instruction transfers on a rising edge where issue_valid and
  // issue_ready are both high; issue_ready is high only in IDLE, so issue_valid
  // in any other state is left unconsumed.
  always_comb begin
    stateNext   = state;
    opNext      = curOp;
    cntNext     = cnt;
    tmrNext     = tmr;
    aluOpNext   = alu_op;
    illegalNext = 1'b0;
    timeoutNext = 1'b0;
    storeDone   = 1'b0;
    wbFromMem   = 1'b0;
    decoded     = decodeOp(opcode);
    case (state)
      IDLE: begin
        if (issue_valid) begin
          if (decoded == OP_BAD) begin
            illegalNext = 1'b1;
          end else begin
            stateNext = EXEC;
            opNext    = decoded;
            cntNext   = latencyOf(decoded);
            aluOpNext = aluCodeOf(decoded);
          end
        end
      end
      EXEC: begin
        if (cnt == '0) begin
          if (curOp == OP_LOAD || curOp == OP_STORE) begin
            stateNext = MEM;
            tmrNext   = '0;
          end else begin
            stateNext = WB;
          end
        end else begin
          cntNext = cnt - CNT_W'(1);
        end
      end
      MEM: begin
        // An ack arriving in the final allowed cycle still completes the access.
        if (mem_ack) begin
          if (curOp == OP_STORE) begin
            stateNext = IDLE;
            storeDone = 1'b1;
          end else begin
            stateNext = WB;
            wbFromMem = 1'b1;
          end
        end else if (tmr == TMR_LAST) begin
          stateNext   = IDLE;
          timeoutNext = 1'b1;
        end else begin
          tmrNext = tmr + TMR_W'(1);
        end
      end
      WB:      stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Outputs are flops loaded from the next-state decode, so each one lines up
  // with the state it describes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      curOp       <= OP_ADD;
      cnt         <= '0;
      tmr         <= '0;
      issue_ready <= 1'b1;
      busy        <= 1'b0;
      alu_en      <= 1'b0;
      alu_op      <= 4'b0000;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      wb_en       <= 1'b0;
      wb_sel_mem  <= 1'b0;
      done        <= 1'b0;
      illegal     <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= stateNext;
      curOp       <= opNext;
      cnt         <= cntNext;
      tmr         <= tmrNext;
      issue_ready <= (stateNext == IDLE);
      busy        <= (stateNext != IDLE);
      alu_en      <= (stateNext == EXEC);
      alu_op      <= aluOpNext;
      mem_req     <= (stateNext == MEM);
      mem_we      <= (stateNext == MEM) && (opNext == OP_STORE);
      wb_en       <= (stateNext == WB);
      wb_sel_mem  <= wbFromMem;
      done        <= (stateNext == WB) || storeDone;
      illegal     <= illegalNext;
      timeout     <= timeoutNext;
    end
  end

  assign stateDbg = state;

endmodule

// File: tb/tb_exec_sequencer.sv
// Bench for exec_sequencer: table of per-instruction expectations plus
// hand-written sequences for back-to-back illegal issue and mid-MEM reset.
module tb_exec_sequencer;
  localparam int MUL_C  = 4;
  localparam int DIV_C  = 32;
  localparam int MEM_TO = 8;
  localparam int NV     = 15;

  logic       clk = 1'b0;
  logic       reset;
  logic       issueValid;
  logic       issueReady;
  logic [5:0] opcode;
  logic       aluEn;
  logic [3:0] aluOp;
  logic       memReq;
  logic       memWe;
  logic       memAck;
  logic       wbEn;
  logic       wbSelMem;
  logic       done;
  logic       illegal;
  logic       timeout;
  logic       busy;
  logic [1:0] stateDbg;

  int nChecks = 0;
  int nFails  = 0;
  logic [4:0] exp_q[$];

  typedef struct {
    string      name;
    logic [5:0] opc;
    int         ackAt;
    bit         noise;
    bit         hold;
    logic [3:0] aluOp;
    int         aluCyc;
    int         memCyc;
    bit         memWe;
    int         wbCyc;
    bit         wbSel;
    int         doneCyc;
    int         toCyc;
    int         illCyc;
    int         interval;
    logic [4:0] ev;
  } vecT;

  vecT vecs[NV];

  exec_sequencer #(.MUL_CYCLES(MUL_C), .DIV_CYCLES(DIV_C), .MEM_TIMEOUT(MEM_TO)) dut (
    .clk(clk), .reset(reset), .issue_valid(issueValid), .issue_ready(issueReady),
    .opcode(opcode), .alu_en(aluEn), .alu_op(aluOp), .mem_req(memReq), .mem_we(memWe),
    .mem_ack(memAck), .wb_en(wbEn), .wb_sel_mem(wbSelMem), .done(done),
    .illegal(illegal), .timeout(timeout), .busy(busy), .stateDbg(stateDbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [13:0] outVec();
    return {issueReady, aluEn, aluOp, memReq, memWe, wbEn, wbSelMem, done, illegal, timeout, busy};
  endfunction

  // scoreboard: one event per retired/faulted instruction
  task automatic popEvent();
    logic [4:0] got;
    logic [4:0] e;
    if (done || illegal || timeout) begin
      got = {done, wbEn, wbSelMem, timeout, illegal};
      if (exp_q.size() == 0) begin
        check("sb_unexpected_event", int'(got), 0);
      end else begin
        e = exp_q.pop_front();
        check("sb_event", int'(got), int'(e));
      end
    end
  endtask

  // driver: issue one instruction at a negedge with issue_ready high, then
  // watch it until issue_ready returns
  task automatic runVec(input vecT v);
    int aluCyc, memCyc, wbCyc, doneCyc, toCyc, illCyc;
    int opErr, weErr, selErr, busyErr, interval;
    aluCyc = 0; memCyc = 0; wbCyc = 0; doneCyc = 0; toCyc = 0; illCyc = 0;
    opErr = 0; weErr = 0; selErr = 0; busyErr = 0; interval = 0;
    exp_q.push_back(v.ev);
    issueValid = 1'b1;
    opcode     = v.opc;
    memAck     = v.noise;
    @(posedge clk);
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(negedge clk);
      if (!v.hold) issueValid = 1'b0;
      if (aluEn) begin
        aluCyc++;
        if (aluOp !== v.aluOp) opErr++;
      end
      if (memReq) begin
        memCyc++;
        if (memWe !== v.memWe) weErr++;
      end
      if (wbEn) begin
        wbCyc++;
        if (wbSelMem !== v.wbSel) selErr++;
      end
      doneCyc += int'(done);
      toCyc   += int'(timeout);
      illCyc  += int'(illegal);
      if (busy === issueReady) busyErr++;
      popEvent();
      memAck = memReq ? (memCyc == v.ackAt) : v.noise;
      if (issueReady) begin
        interval = cyc;
        break;
      end
    end
    issueValid = 1'b0;
    memAck     = 1'b0;
    check({v.name, ".alu_cycles"}, aluCyc, v.aluCyc);
    check({v.name, ".alu_op_errs"}, opErr, 0);
    check({v.name, ".mem_cycles"}, memCyc, v.memCyc);
    check({v.name, ".mem_we_errs"}, weErr, 0);
    check({v.name, ".wb_cycles"}, wbCyc, v.wbCyc);
    check({v.name, ".wb_sel_errs"}, selErr, 0);
    check({v.name, ".done_cycles"}, doneCyc, v.doneCyc);
    check({v.name, ".timeout_cycles"}, toCyc, v.toCyc);
    check({v.name, ".illegal_cycles"}, illCyc, v.illCyc);
    check({v.name, ".busy_errs"}, busyErr, 0);
    check({v.name, ".issue_interval"}, interval, v.interval);
  endtask

  initial begin
    //          name               opc        ack nz hd op    alu mem we wb sel dn to il int ev
    vecs[0]  = '{"ADD",            6'b011111, 0, 0, 0, 4'd0, 1,  0, 0, 1, 0, 1, 0, 0, 3,  5'b11000};
    vecs[1]  = '{"SUB",            6'b011110, 0, 0, 0, 4'd1, 1,  0, 0, 1, 0, 1, 0, 0, 3,  5'b11000};
    vecs[2]  = '{"MUL",            6'b011101, 0, 0, 0, 4'd2, 4,  0, 0, 1, 0, 1, 0, 0, 6,  5'b11000};
    vecs[3]  = '{"DIV_hold",       6'b011100, 0, 0, 1, 4'd3, 32, 0, 0, 1, 0, 1, 0, 0, 34, 5'b11000};
    vecs[4]  = '{"LOAD_ack3",      6'b100001, 3, 0, 0, 4'd0, 1,  3, 0, 1, 1, 1, 0, 0, 6,  5'b11100};
    vecs[5]  = '{"STORE_ack1",     6'b101010, 1, 0, 0, 4'd0, 1,  1, 1, 0, 0, 1, 0, 0, 3,  5'b10000};
    vecs[6]  = '{"LOAD_timeout",   6'b100001, 0, 0, 0, 4'd0, 1,  8, 0, 0, 0, 0, 1, 0, 10, 5'b00010};
    vecs[7]  = '{"LOAD_ack8",      6'b100001, 8, 0, 0, 4'd0, 1,  8, 0, 1, 1, 1, 0, 0, 11, 5'b11100};
    vecs[8]  = '{"STORE_ack8",     6'b101010, 8, 0, 0, 4'd0, 1,  8, 1, 0, 0, 1, 0, 0, 10, 5'b10000};
    vecs[9]  = '{"ADD_ack_noise",  6'b011111, 0, 1, 0, 4'd0, 1,  0, 0, 1, 0, 1, 0, 0, 3,  5'b11000};
    vecs[10] = '{"LOAD_ack2_noise",6'b100001, 2, 1, 0, 4'd0, 1,  2, 0, 1, 1, 1, 0, 0, 5,  5'b11100};
    vecs[11] = '{"MUL_hold",       6'b011101, 0, 0, 1, 4'd2, 4,  0, 0, 1, 0, 1, 0, 0, 6,  5'b11000};
    vecs[12] = '{"ILL_00",         6'b000000, 0, 0, 0, 4'd0, 0,  0, 0, 0, 0, 0, 0, 1, 1,  5'b00001};
    vecs[13] = '{"ILL_3F",         6'b111111, 0, 0, 0, 4'd0, 0,  0, 0, 0, 0, 0, 0, 1, 1,  5'b00001};
    vecs[14] = '{"STORE_timeout",  6'b101010, 0, 0, 0, 4'd0, 1,  8, 1, 0, 0, 0, 1, 0, 10, 5'b00010};

    reset = 1'b1; issueValid = 1'b0; opcode = 6'b0; memAck = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", int'(outVec()), int'(14'h2000));
    check("reset_state", int'(stateDbg), 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_outputs", int'(outVec()), int'(14'h2000));

    for (int i = 0; i < NV; i++) runVec(vecs[i]);
    for (int i = 0; i < 6; i++) runVec(vecs[$urandom_range(0, NV - 1)]);

    // back-to-back illegal opcodes on three consecutive edges
    issueValid = 1'b1;
    opcode     = 6'b000000;
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(5'b00001);
      if (i == 4) void'(exp_q.pop_back());
      @(negedge clk);
      if (i == 3) issueValid = 1'b0;
      check($sformatf("b2b_illegal_%0d", i), int'(illegal), (i <= 3) ? 1 : 0);
      check($sformatf("b2b_busy_%0d", i), int'(busy), 0);
      popEvent();
    end

    // reset in the middle of a LOAD's memory phase
    issueValid = 1'b1;
    opcode     = 6'b100001;
    @(posedge clk);
    for (int i = 0; i < 10 && !memReq; i++) begin
      @(negedge clk);
      issueValid = 1'b0;
    end
    issueValid = 1'b0;
    check("midmem_req_high", int'(memReq), 1);
    #2 reset = 1'b1;
    #1 check("async_reset_drops_req", int'(memReq), 0);
    check("async_reset_outputs", int'(outVec()), int'(14'h2000));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_outputs", int'(outVec()), int'(14'h2000));
    check("post_reset_state", int'(stateDbg), 0);
    runVec(vecs[1]);

    check("sb_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
